// File: rtl/multu_unit.sv
// multu_unit: 32-cycle radix-2 shift-add unsigned multiplier with HI/LO.
// Also services MTHI/MTLO writes and drives busy/stall to the pipeline.
//
// Ports:
//   clk, rst         rising-edge clock, synchronous active-high reset
//   start            issue MULTU (sampled with opa/opb)
//   opa, opb         multiplicand (rs) and multiplier (rt)
//   hi_we, lo_we     MTHI/MTLO write strobes, data on wdata
//   busy             registered, high while iterating
//   stall            busy | start, freezes IF/ID
//   done             registered one-cycle completion pulse
//   hi, lo           architectural HI/LO registers
module multu_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] opa,
    input  logic [WIDTH-1:0] opb,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } state_t;

    state_t             state_q, state_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [WIDTH-1:0]   mcand_q, mcand_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic [2*WIDTH:0]   acc_q, acc_d;

    logic [WIDTH:0]     upper_sum;
    logic [2*WIDTH:0]   acc_step;
    logic               last_iter;

    always_comb begin
        // Upper half plus optional multiplicand; the extra bit keeps
        // the carry so the following shift never loses it.
        upper_sum = acc_q[2*WIDTH:WIDTH]
                  + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
        acc_step  = {1'b0, upper_sum, acc_q[WIDTH-1:1]};
        last_iter = (count_q == CNT_W'(WIDTH - 1));

        state_d = state_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        count_d = count_q;
        mcand_d = mcand_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        acc_d   = acc_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    // start wins over a coincident MTHI/MTLO
                    state_d = S_BUSY;
                    busy_d  = 1'b1;
                    mcand_d = opa;
                    acc_d   = {{(WIDTH+1){1'b0}}, opb};
                    count_d = '0;
                end else begin
                    if (hi_we) hi_d = wdata;
                    if (lo_we) lo_d = wdata;
                end
            end
            S_BUSY: begin
                acc_d   = acc_step;
                count_d = count_q + CNT_W'(1);
                if (last_iter) begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    hi_d    = acc_step[2*WIDTH-1:WIDTH];
                    lo_d    = acc_step[WIDTH-1:0];
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            count_q <= '0;
            mcand_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            acc_q   <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            count_q <= count_d;
            mcand_q <= mcand_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            acc_q   <= acc_d;
        end
    end

    assign busy  = busy_q;
    assign stall = busy_q | start;
    assign done  = done_q;
    assign hi    = hi_q;
    assign lo    = lo_q;

endmodule

// File: tb/tb_multu_unit.sv
// tb_multu_unit: scoreboard bench for multu_unit.
// Products come from plain 64-bit arithmetic; a monitor checks them on done.
module tb_multu_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst, start, hi_we, lo_we;
    logic [W-1:0] opa, opb, wdata;
    logic         busy, stall, done;
    logic [W-1:0] hi, lo;

    int checks = 0;
    int failures = 0;
    int done_seen = 0;
    int done_exp = 0;

    logic [2*W-1:0] exp_q[$];
    logic [2*W-1:0] mon_p;
    logic [W-1:0]   m_hi = '0;
    logic [W-1:0]   m_lo = '0;

    always #5 clk = ~clk;

    multu_unit #(.WIDTH(W), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start),
        .opa(opa), .opb(opb),
        .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
        .busy(busy), .stall(stall), .done(done),
        .hi(hi), .lo(lo)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest issued multiply.
    always @(negedge clk) begin
        if (rst === 1'b0 && done === 1'b1) begin
            done_seen++;
            if (exp_q.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                mon_p = exp_q.pop_front();
                chk("product", {hi, lo}, mon_p);
            end
        end
    end

    // Entered at posedge+1 with the unit idle; returns at posedge+1 of
    // the done cycle so the caller may issue back-to-back.
    task automatic mul(input logic [W-1:0] a, input logic [W-1:0] b,
                       input int inj_start, input int inj_lo);
        logic [63:0] prod;
        int bad_busy;
        int bad_hold;
        prod = 64'(a) * 64'(b);
        bad_busy = 0;
        bad_hold = 0;
        opa = a;
        opb = b;
        start = 1'b1;
        @(negedge clk);
        chk("stall_on_start", {63'd0, stall}, 64'd1);
        @(posedge clk);
        #1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        exp_q.push_back(prod);
        done_exp++;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            if (busy !== 1'b1 || done !== 1'b0 || stall !== 1'b1)
                bad_busy++;
            if (hi !== m_hi || lo !== m_lo)
                bad_hold++;
            start = (i == inj_start);
            if (i == inj_start) begin
                opa = 32'd7;
                opb = 32'd9;
            end
            lo_we = (i == inj_lo);
            if (i == inj_lo) wdata = 32'h5A5A_0F0F;
        end
        chk("busy_window", 64'(bad_busy), 64'd0);
        chk("hold_while_busy", 64'(bad_hold), 64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;
        lo_we = 1'b0;
        chk("done_pulse", {62'd0, busy, done}, 64'd1);
        m_hi = prod[63:32];
        m_lo = prod[31:0];
    endtask

    task automatic idle(input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (busy !== 1'b0 || done !== 1'b0) bad++;
        end
        @(posedge clk);
        #1;
        chk("idle_quiet", 64'(bad), 64'd0);
    endtask

    task automatic wr(input logic hw, input logic lw,
                      input logic [W-1:0] d);
        hi_we = hw;
        lo_we = lw;
        wdata = d;
        @(posedge clk);
        #1;
        hi_we = 1'b0;
        lo_we = 1'b0;
        if (hw) m_hi = d;
        if (lw) m_lo = d;
        chk("mt_hi", 64'(hi), 64'(m_hi));
        chk("mt_lo", 64'(lo), 64'(m_lo));
    endtask

    task automatic mul_abort(input logic [W-1:0] a, input logic [W-1:0] b,
                             input int at);
        opa = a;
        opb = b;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 1; i <= at; i++) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_hi = '0;
        m_lo = '0;
        chk("abort_state", {busy, done, hi, lo}, 64'd0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        hi_we = 1'b0;
        lo_we = 1'b0;
        opa = '0;
        opb = '0;
        wdata = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_state", {busy, done, stall, hi, lo}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        mul(32'd3, 32'd5, 0, 0);
        idle(3);
        mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        idle(2);
        mul(32'd100, 32'd200, 10, 0);
        idle(3);
        mul(32'd12345, 32'd678, 0, 0);
        mul(32'd2, 32'd4, 0, 0);
        idle(2);

        wr(1'b1, 1'b0, 32'hA5A5_A5A5);
        wr(1'b0, 1'b1, 32'h0000_1234);
        wr(1'b1, 1'b1, 32'hCAFE_BABE);
        mul(32'd5, 32'd6, 0, 12);
        idle(1);

        hi_we = 1'b1;
        lo_we = 1'b1;
        wdata = 32'hFFFF_0000;
        mul(32'd9, 32'd9, 0, 0);
        idle(1);

        mul(32'd0, 32'hFFFF_FFFF, 0, 0);
        mul(32'hFFFF_FFFF, 32'd0, 0, 0);
        mul(32'd1, 32'hFFFF_FFFF, 0, 0);
        mul(32'h8000_0000, 32'd2, 0, 0);
        idle(1);

        for (int k = 0; k < 8; k++) begin
            mul($urandom, $urandom, 0, 0);
            if ($urandom_range(0, 1) == 1) idle(1);
        end
        idle(1);

        mul_abort(32'hDEAD_BEEF, 32'h1234_5678, 12);
        idle(40);

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("done_count", 64'(done_seen), 64'(done_exp));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
